// File: rtl/image_write_ctrl.sv
// Frame sequencer feeding the BMP writer: counts one WIDTH x HEIGHT frame of pixel pairs, then waits for Write_Done.
// Latency: a beat accepted at edge N drives hsync and DATA_WRITE_* during cycle N+1.
// Backpressure: in_ready depends on state only; it is high in ACTIVE and low elsewhere. Optional line blanking uses IMAGE_WRITE_CTRL_HBLANK_EN.
module image_write_ctrl #(
    parameter int WIDTH        = 768,
    parameter int HEIGHT       = 512,
    parameter int HBLANK       = 160,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r0,
    input  logic [7:0]  in_g0,
    input  logic [7:0]  in_b0,
    input  logic [7:0]  in_r1,
    input  logic [7:0]  in_g1,
    input  logic [7:0]  in_b1,
    output logic        hsync,
    output logic [7:0]  DATA_WRITE_R0,
    output logic [7:0]  DATA_WRITE_G0,
    output logic [7:0]  DATA_WRITE_B0,
    output logic [7:0]  DATA_WRITE_R1,
    output logic [7:0]  DATA_WRITE_G1,
    output logic [7:0]  DATA_WRITE_B1,
    input  logic        Write_Done,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [15:0] col,
    output logic [15:0] row
);

    // Parameter sanity: odd widths cannot be split into pixel pairs; zero blanking or timeout is meaningless.
    if ((WIDTH % 2) != 0 || WIDTH < 2 || HEIGHT < 1 || HBLANK < 1 || DONE_TIMEOUT < 1) begin : g_bad_param
        $error("image_write_ctrl: illegal parameter set");
    end

    localparam logic [15:0] LAST_COL = 16'(WIDTH / 2 - 1);
    localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
    localparam logic [15:0] TO_LAST  = 16'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_BLANK,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        line_end;
    logic        last_row;
    logic        timeout_evt;
    logic [15:0] to_cnt;

    assign in_ready    = (state == S_ACTIVE);
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_DONE);
    assign accept      = in_valid & in_ready;
    assign last_row    = (row == LAST_ROW);
    assign line_end    = accept & (col == LAST_COL);
    // Write_Done wins over a timeout landing in the same cycle.
    assign timeout_evt = (state == S_WAIT_DONE) & ~Write_Done & (to_cnt == TO_LAST);

`ifdef IMAGE_WRITE_CTRL_HBLANK_EN
    localparam logic [15:0] BLANK_LAST = 16'(HBLANK - 1);
    logic [15:0] blank_cnt;

    // Blanking counter: counts cycles spent in BLANK, reset whenever elsewhere.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            blank_cnt <= '0;
        end else if (state == S_BLANK) begin
            blank_cnt <= blank_cnt + 16'd1;
        end else begin
            blank_cnt <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the frame sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (line_end) begin
                    if (last_row) begin
                        state_nxt = S_WAIT_DONE;
                    end else begin
`ifdef IMAGE_WRITE_CTRL_HBLANK_EN
                        state_nxt = S_BLANK;
`else
                        state_nxt = S_ACTIVE;
`endif
                    end
                end
            end
`ifdef IMAGE_WRITE_CTRL_HBLANK_EN
            S_BLANK: begin
                if (blank_cnt == BLANK_LAST) state_nxt = S_ACTIVE;
            end
`endif
            S_WAIT_DONE: begin
                if (Write_Done) begin
                    state_nxt = S_DONE;
                end else if (timeout_evt) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Write strobe and pixel data: strobe for one cycle per accepted beat, data held otherwise.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync         <= 1'b0;
            DATA_WRITE_R0 <= '0;
            DATA_WRITE_G0 <= '0;
            DATA_WRITE_B0 <= '0;
            DATA_WRITE_R1 <= '0;
            DATA_WRITE_G1 <= '0;
            DATA_WRITE_B1 <= '0;
        end else begin
            hsync <= accept;
            if (accept) begin
                DATA_WRITE_R0 <= in_r0;
                DATA_WRITE_G0 <= in_g0;
                DATA_WRITE_B0 <= in_b0;
                DATA_WRITE_R1 <= in_r1;
                DATA_WRITE_G1 <= in_g1;
                DATA_WRITE_B1 <= in_b1;
            end
        end
    end

    // Column/row position; row stays on the last line once the frame is complete.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col <= '0;
            row <= '0;
        end else if (state == S_IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (line_end) begin
                col <= '0;
                if (!last_row) row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

    // Sticky error: set by a Write_Done timeout, cleared by the next accepted start.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= 1'b0;
        end else if (timeout_evt) begin
            err <= 1'b1;
        end
    end

    // Timeout counter: runs from 0 on entry to WAIT_DONE.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            to_cnt <= '0;
        end else if (state == S_WAIT_DONE) begin
            to_cnt <= to_cnt + 16'd1;
        end else begin
            to_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_image_write_ctrl.sv
// Directed bench for image_write_ctrl on an 8x4 frame (4 pixel pairs per line).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Build with IMAGE_WRITE_CTRL_HBLANK_EN to also check 3-cycle line blanking.
module tb_image_write_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
    logic        hsync;
    logic [7:0]  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
    logic [7:0]  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;
    logic        Write_Done;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [15:0] col;
    logic [15:0] row;

    int vecs = 0;
    int miscompares = 0;
    int seq = 0;

    always #5 HCLK = ~HCLK;

    image_write_ctrl #(
        .WIDTH(8), .HEIGHT(4), .HBLANK(3), .DONE_TIMEOUT(16)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
        .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
        .hsync(hsync),
        .DATA_WRITE_R0(DATA_WRITE_R0), .DATA_WRITE_G0(DATA_WRITE_G0), .DATA_WRITE_B0(DATA_WRITE_B0),
        .DATA_WRITE_R1(DATA_WRITE_R1), .DATA_WRITE_G1(DATA_WRITE_G1), .DATA_WRITE_B1(DATA_WRITE_B1),
        .Write_Done(Write_Done), .busy(busy), .frame_done(frame_done), .err(err),
        .col(col), .row(row)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_pix(input int base);
        in_r0 = 8'(base);
        in_g0 = 8'(base + 16);
        in_b0 = 8'(base + 32);
        in_r1 = 8'(base + 48);
        in_g1 = 8'(base + 64);
        in_b1 = 8'(base + 80);
    endtask

    // Offer n beats with in_valid high, waiting out any blanking, bounded by a cycle budget.
    task automatic feed(input int n);
        int got = 0;
        int budget = 0;
        in_valid = 1'b1;
        while (got < n && budget < 200) begin
            set_pix(seq);
            if (in_ready) begin
                got++;
                seq++;
            end
            tick();
            budget++;
        end
        in_valid = 1'b0;
        if (got < n) check("feed_budget", got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; start = 1'b0; in_valid = 1'b1; Write_Done = 1'b0;
        set_pix(0);

        // Reset state, in_valid already high.
        #3;
        check("rst_hsync", hsync, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_colrow", {col, row}, 0);
        check("rst_data", {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
                           DATA_WRITE_R1}, 0);
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        check("idle_ready", in_ready, 0);
        check("idle_hsync", hsync, 0);
        check("idle_busy", busy, 0);

        // Full frame, in_valid held high.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        for (int n = 1; n <= 16; n++) begin
            set_pix(n);
            check("pre_ready", in_ready, 1);
            tick();
            check("hsync", hsync, 1);
            check("r0", DATA_WRITE_R0, n);
            check("b1", DATA_WRITE_B1, n + 80);
            check("col", col, n % 4);
            check("row", row, (n == 16) ? 3 : n / 4);
`ifdef IMAGE_WRITE_CTRL_HBLANK_EN
            if (n % 4 == 0 && n < 16) begin
                for (int b = 0; b < 3; b++) begin
                    check("blank_ready", in_ready, 0);
                    tick();
                end
            end
`endif
        end
        check("end_ready", in_ready, 0);
        check("end_busy", busy, 1);
        Write_Done = 1'b1;
        tick();
        Write_Done = 1'b0;
        check("fd_pulse", frame_done, 1);
        check("fd_busy", busy, 1);
        check("fd_hsync", hsync, 0);
        tick();
        check("fd_clear", frame_done, 0);
        check("post_busy", busy, 0);
        check("post_hold", DATA_WRITE_G1, 16 + 64);

        // in_valid pattern 1,0,0,1 then complete the frame and let WAIT_DONE time out.
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f2_colrow", {col, row}, 0);
        in_valid = 1'b1;
        set_pix(8'hA1);
        tick();
        in_valid = 1'b0;
        set_pix(8'h11);
        check("gap_h0", hsync, 1);
        check("gap_d0", DATA_WRITE_R0, 8'hA1);
        tick();
        check("gap_h1", hsync, 0);
        check("gap_d1", DATA_WRITE_G1, 8'hE1);
        tick();
        check("gap_h2", hsync, 0);
        check("gap_d2", DATA_WRITE_R0, 8'hA1);
        in_valid = 1'b1;
        set_pix(8'h42);
        tick();
        in_valid = 1'b0;
        check("gap_h3", hsync, 1);
        check("gap_d3", DATA_WRITE_B0, 8'h62);
        check("gap_col", col, 2);
        feed(14);
        for (int c = 0; c < 16; c++) begin
            check("wait_busy", busy, 1);
            check("wait_err", err, 0);
            check("wait_fd", frame_done, 0);
            tick();
        end
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_fd", frame_done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_clear", err, 0);
        check("restart_busy", busy, 1);

        // Reset in the middle of a frame.
        feed(7);
        check("pre_rst_col", col, 3);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_colrow", {col, row}, 0);
        check("mid_rst_r0", DATA_WRITE_R0, 0);
        #2;
        HRESETn = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        set_pix(8'h33);
        tick();
        in_valid = 1'b0;
        check("new_col", col, 1);
        check("new_row", row, 0);
        check("new_r0", DATA_WRITE_R0, 8'h33);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
